// File: rtl/game_sequencer.sv
// game_sequencer: frame-level scheduler for the shooter game core.
//
// Owns the top-level game state and, while playing, steps the shared object datapath through
// DRAW -> MOVE -> COLLISION -> CALCVALUE -> CHECKING -> WAITING once per VGA frame, with stage
// boundaries locked to vertical blanking. Also advances the enemy movement phase and arbitrates
// player fire against a cooldown.
//
// Optional feature: define GAME_OVERRUN_CHECK_EN to turn a vblank fall that arrives while the
// datapath is still sequencing (MOVE..CHECKING) into the ERROR game state.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             single-cycle start pulse (debounced upstream)
//   vblank_i            high during vertical blanking
//   move/coll/calc_done_i  stage completion pulses from the datapath
//   enemy_alive_i       number of live enemies
//   player_hit_i        player was hit (valid in CHECKING)
//   fire_req_i          player wants to fire
//   game_state_o        IDLE 000, PLAYING 001, VICTORY 010, DEFEAT 011, ERROR 100
//   onplay_state_o      DRAW 000, MOVE 001, COLLISION 010, CALCVALUE 011, CHECKING 100, WAITING 101
//   phase_o             enemy movement phase PHASE_1..PHASE_4
//   move/coll/calc_start_o  one-cycle stage start pulses
//   game_init_o         one-cycle pulse: datapath reloads initial positions
//   draw_en_o           high while in DRAW
//   fire_grant_o        one-cycle fire grant
module game_sequencer #(
  parameter int unsigned MAX_ENEMY           = 15,
  parameter int unsigned MAX_PHASE_CNT       = 124,
  parameter int unsigned MAX_PLAYER_COOLDOWN = 11,
  localparam int unsigned EnemyW             = $clog2(MAX_ENEMY + 1),
  localparam int unsigned CdW                = $clog2(MAX_PLAYER_COOLDOWN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              vblank_i,
  input  logic              move_done_i,
  input  logic              coll_done_i,
  input  logic              calc_done_i,
  input  logic [EnemyW-1:0] enemy_alive_i,
  input  logic              player_hit_i,
  input  logic              fire_req_i,
  output logic [2:0]        game_state_o,
  output logic [2:0]        onplay_state_o,
  output logic [1:0]        phase_o,
  output logic              move_start_o,
  output logic              coll_start_o,
  output logic              calc_start_o,
  output logic              game_init_o,
  output logic              draw_en_o,
  output logic              fire_grant_o
);

  typedef enum logic [2:0] {
    GameIdle    = 3'b000,
    GamePlaying = 3'b001,
    GameVictory = 3'b010,
    GameDefeat  = 3'b011,
    GameError   = 3'b100
  } game_e;

  typedef enum logic [2:0] {
    OnDraw      = 3'b000,
    OnMove      = 3'b001,
    OnCollision = 3'b010,
    OnCalcValue = 3'b011,
    OnChecking  = 3'b100,
    OnWaiting   = 3'b101
  } onplay_e;

  game_e          game_q, game_d;
  onplay_e        onplay_q, onplay_d;
  logic [1:0]     phase_q, phase_d;
  logic [6:0]     frame_cnt_q, frame_cnt_d;
  logic [CdW-1:0] cooldown_q, cooldown_d;
  logic           vblank_q;
  logic           move_start_q, coll_start_q, calc_start_q;
  logic           game_init_q, game_init_d;
  logic           fire_grant_q, fire_grant_d;
  logic           vb_rise, vb_fall, overrun;

  assign vb_rise = vblank_i & ~vblank_q;
  assign vb_fall = ~vblank_i & vblank_q;

  always_comb begin
    game_d       = game_q;
    onplay_d     = onplay_q;
    phase_d      = phase_q;
    frame_cnt_d  = frame_cnt_q;
    cooldown_d   = cooldown_q;
    game_init_d  = 1'b0;
    fire_grant_d = 1'b0;
    overrun      = 1'b0;
`ifdef GAME_OVERRUN_CHECK_EN
    overrun = vb_fall && (onplay_q inside {OnMove, OnCollision, OnCalcValue, OnChecking});
`else
    overrun = 1'b0;
`endif

    if (game_q != GamePlaying) begin
      onplay_d = OnWaiting;
      if (start_i) begin
        game_d      = GamePlaying;
        game_init_d = 1'b1;
        phase_d     = 2'd0;
        frame_cnt_d = '0;
        cooldown_d  = '0;
      end
    end else if (overrun) begin
      game_d   = GameError;
      onplay_d = OnWaiting;
    end else begin
      // Done pulses are ignored in the cycle the stage's start pulse is out.
      unique case (onplay_q)
        OnWaiting:   if (vb_fall) onplay_d = OnDraw;
        OnDraw:      if (vb_rise) onplay_d = OnMove;
        OnMove:      if (move_done_i && !move_start_q) onplay_d = OnCollision;
        OnCollision: if (coll_done_i && !coll_start_q) onplay_d = OnCalcValue;
        OnCalcValue: if (calc_done_i && !calc_start_q) onplay_d = OnChecking;
        OnChecking: begin
          onplay_d = OnWaiting;
          if (player_hit_i) begin
            game_d = GameDefeat;
          end else if (enemy_alive_i == '0) begin
            game_d = GameVictory;
          end else begin
            if (frame_cnt_q == 7'(MAX_PHASE_CNT)) begin
              frame_cnt_d = '0;
              phase_d     = phase_q + 2'd1;
            end else begin
              frame_cnt_d = frame_cnt_q + 7'd1;
            end
            if (cooldown_q == '0 && fire_req_i) begin
              fire_grant_d = 1'b1;
              cooldown_d   = CdW'(MAX_PLAYER_COOLDOWN);
            end else if (cooldown_q != '0) begin
              cooldown_d = cooldown_q - CdW'(1);
            end
          end
        end
        default: onplay_d = OnWaiting;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      game_q       <= GameIdle;
      onplay_q     <= OnWaiting;
      phase_q      <= 2'd0;
      frame_cnt_q  <= '0;
      cooldown_q   <= '0;
      vblank_q     <= 1'b0;
      move_start_q <= 1'b0;
      coll_start_q <= 1'b0;
      calc_start_q <= 1'b0;
      game_init_q  <= 1'b0;
      fire_grant_q <= 1'b0;
    end else begin
      game_q       <= game_d;
      onplay_q     <= onplay_d;
      phase_q      <= phase_d;
      frame_cnt_q  <= frame_cnt_d;
      cooldown_q   <= cooldown_d;
      vblank_q     <= vblank_i;
      // Start pulses coincide with the first cycle of their stage.
      move_start_q <= (onplay_d == OnMove) && (onplay_q != OnMove);
      coll_start_q <= (onplay_d == OnCollision) && (onplay_q != OnCollision);
      calc_start_q <= (onplay_d == OnCalcValue) && (onplay_q != OnCalcValue);
      game_init_q  <= game_init_d;
      fire_grant_q <= fire_grant_d;
    end
  end

  assign game_state_o   = game_q;
  assign onplay_state_o = onplay_q;
  assign phase_o        = phase_q;
  assign move_start_o   = move_start_q;
  assign coll_start_o   = coll_start_q;
  assign calc_start_o   = calc_start_q;
  assign game_init_o    = game_init_q;
  assign draw_en_o      = (onplay_q == OnDraw);
  assign fire_grant_o   = fire_grant_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed self-checking bench for game_sequencer.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, vblank, move_done, coll_done, calc_done, player_hit, fire_req;
  logic [3:0] enemy_alive;
  logic [2:0] game_state, onplay_state;
  logic [1:0] phase;
  logic       move_start, coll_start, calc_start, game_init, draw_en, fire_grant;

  int errors = 0;
  int checks = 0;

  game_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .vblank_i       (vblank),
    .move_done_i    (move_done),
    .coll_done_i    (coll_done),
    .calc_done_i    (calc_done),
    .enemy_alive_i  (enemy_alive),
    .player_hit_i   (player_hit),
    .fire_req_i     (fire_req),
    .game_state_o   (game_state),
    .onplay_state_o (onplay_state),
    .phase_o        (phase),
    .move_start_o   (move_start),
    .coll_start_o   (coll_start),
    .calc_start_o   (calc_start),
    .game_init_o    (game_init),
    .draw_en_o      (draw_en),
    .fire_grant_o   (fire_grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame from WAITING with vblank high; dones come 2 cycles after each start.
  task automatic run_frame(input bit chk_order, output bit grant_seen);
    logic [2:0] starts;
    vblank = 1'b0;
    tick();
    if (chk_order) begin
      chk("draw_state", 32'(onplay_state), 32'd0);
      chk("draw_en", 32'(draw_en), 32'd1);
    end
    vblank = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      starts = {calc_start, coll_start, move_start};
      if (chk_order) begin
        chk("stage_state", 32'(onplay_state), 32'(s + 1));
        chk("stage_start", 32'(starts), 32'(3'b001 << s));
      end
      tick();
      tick();
      case (s)
        0:       move_done = 1'b1;
        1:       coll_done = 1'b1;
        default: calc_done = 1'b1;
      endcase
      tick();
      move_done = 1'b0;
      coll_done = 1'b0;
      calc_done = 1'b0;
    end
    if (chk_order) chk("checking_state", 32'(onplay_state), 32'd4);
    tick();
    grant_seen = fire_grant;
    if (chk_order) chk("after_check_state", 32'(onplay_state), 32'd5);
  endtask

  task automatic run_frames(input int n);
    bit g;
    for (int i = 0; i < n; i++) run_frame(1'b0, g);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    bit g;
    rst_n = 1'b0; start = 1'b0; vblank = 1'b1;
    move_done = 1'b0; coll_done = 1'b0; calc_done = 1'b0;
    enemy_alive = 4'd5; player_hit = 1'b0; fire_req = 1'b0;
    #12;
    chk("rst_game", 32'(game_state), 32'd0);
    chk("rst_onplay", 32'(onplay_state), 32'd5);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_pulses", 32'({move_start, coll_start, calc_start, game_init, draw_en, fire_grant}),
        32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_hold", 32'(game_state), 32'd0);

    // Start: PLAYING and game_init one cycle later.
    pulse_start();
    chk("start_game", 32'(game_state), 32'd1);
    chk("start_init", 32'(game_init), 32'd1);
    chk("start_onplay", 32'(onplay_state), 32'd5);
    tick();
    chk("init_oneshot", 32'(game_init), 32'd0);

    // Full frame with order checks.
    run_frame(1'b1, g);
    chk("frame1_grant", 32'(g), 32'd0);
    chk("frame1_cnt", 32'(dut.frame_cnt_q), 32'd1);
    chk("frame1_game", 32'(game_state), 32'd1);

    // Fire held for 30 frames: grants on frames 1, 13, 25.
    fire_req = 1'b1;
    for (int f = 1; f <= 30; f++) begin
      run_frame(1'b0, g);
      chk($sformatf("fire_f%0d", f), 32'(g), 32'(f % 12 == 1));
    end
    fire_req = 1'b0;

    // start ignored while PLAYING.
    pulse_start();
    chk("start_ign_init", 32'(game_init), 32'd0);
    chk("start_ign_game", 32'(game_state), 32'd1);
    chk("start_ign_cnt", 32'(dut.frame_cnt_q), 32'd31);

    // Phase progression, counting frames since game start (31 so far).
    run_frames(93);
    chk("phase_f124", 32'(phase), 32'd0);
    run_frames(1);
    chk("phase_f125", 32'(phase), 32'd1);
    run_frames(125);
    chk("phase_f250", 32'(phase), 32'd2);
    run_frames(125);
    chk("phase_f375", 32'(phase), 32'd3);
    run_frames(125);
    chk("phase_f500", 32'(phase), 32'd0);
    chk("cnt_f500", 32'(dut.frame_cnt_q), 32'd0);

    // Hit and no enemies together: DEFEAT wins, and no fire grant at game end.
    player_hit = 1'b1; enemy_alive = 4'd0; fire_req = 1'b1;
    run_frame(1'b0, g);
    chk("defeat_state", 32'(game_state), 32'd3);
    chk("defeat_nogrant", 32'(g), 32'd0);
    player_hit = 1'b0; fire_req = 1'b0;
    vblank = 1'b0;
    tick();
    tick();
    chk("defeat_hold_onplay", 32'(onplay_state), 32'd5);
    chk("defeat_hold_game", 32'(game_state), 32'd3);
    vblank = 1'b1;
    tick();
    pulse_start();
    chk("restart_game", 32'(game_state), 32'd1);
    chk("restart_init", 32'(game_init), 32'd1);
    chk("restart_phase", 32'(phase), 32'd0);
    chk("restart_cnt", 32'(dut.frame_cnt_q), 32'd0);

    // Victory.
    run_frame(1'b0, g);
    chk("victory_state", 32'(game_state), 32'd2);
    pulse_start();
    chk("restart2_game", 32'(game_state), 32'd1);
    enemy_alive = 4'd5;

    // Overrun: calc_done withheld past the vblank fall.
    vblank = 1'b0; tick();
    vblank = 1'b1; tick();
    tick(); tick(); move_done = 1'b1; tick(); move_done = 1'b0;
    tick(); tick(); coll_done = 1'b1; tick(); coll_done = 1'b0;
    chk("ovr_calc_state", 32'(onplay_state), 32'd3);
    vblank = 1'b0;
    tick();
`ifdef GAME_OVERRUN_CHECK_EN
    chk("ovr_error", 32'(game_state), 32'd4);
    chk("ovr_onplay", 32'(onplay_state), 32'd5);
    vblank = 1'b1; tick();
    vblank = 1'b0; tick();
    chk("ovr_error_hold", 32'(game_state), 32'd4);
    vblank = 1'b1; tick();
    pulse_start();
    chk("ovr_restart", 32'(game_state), 32'd1);
    tick();
`else
    chk("ovr_no_error", 32'(game_state), 32'd1);
    chk("ovr_still_calc", 32'(onplay_state), 32'd3);
    calc_done = 1'b1; tick(); calc_done = 1'b0;
    chk("ovr_late_check", 32'(onplay_state), 32'd4);
    tick();
    tick();
    tick();
    chk("ovr_draw_skipped", 32'(onplay_state), 32'd5);
    vblank = 1'b1; tick();
    chk("ovr_rise_ignored", 32'(onplay_state), 32'd5);
`endif
    run_frame(1'b1, g);
    chk("resume_game", 32'(game_state), 32'd1);

    // Asynchronous reset in the middle of MOVE drops the start pulse.
    vblank = 1'b0; tick();
    vblank = 1'b1; tick();
    chk("pre_rst_move", 32'(move_start), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("async_rst_game", 32'(game_state), 32'd0);
    chk("async_rst_onplay", 32'(onplay_state), 32'd5);
    chk("async_rst_pulse", 32'(move_start), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
